// File: rtl/reset_sequencer.sv
// Board-level reset sequencer: PLL lock + debounced button gate a staggered per-channel release.
// Latency: lock rise -> channel 0 release in SYNC_STAGES+1+HOLD_CYCLES edges, then STAGGER_CYCLES per channel.
// Backpressure: none; any loss of lock or button press re-asserts every channel on the next edge.
module reset_sequencer #(
  parameter int N_CH            = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGGER_CYCLES  = 4,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic            CLK_100MHZ,
  input  logic            RESET,
  input  logic            pll_locked,
  input  logic            btn_n,
  output logic [N_CH-1:0] rst_n_out,
  output logic            ready,
  output logic [1:0]      state
);

  localparam int MAX_CNT = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int CH_W    = $clog2(N_CH + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CH_W-1:0]  LAST_CH      = CH_W'(N_CH - 1);
  localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_WAIT_LOCK = 2'd0;
  localparam logic [1:0] S_HOLD      = 2'd1;
  localparam logic [1:0] S_STAGGER   = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   locked_s;
  logic                   btn_s;
  logic                   btn_db;
  logic [DB_W-1:0]        db_cnt;
  logic                   ok;
  logic [CNT_W-1:0]       cnt;
  logic [CH_W-1:0]        ch;

  assign locked_s = lock_sync[SYNC_STAGES-1];
  assign btn_s    = btn_sync[SYNC_STAGES-1];
  // Lock loss is acted on immediately; only the button is filtered.
  assign ok       = locked_s & btn_db;

  // Synchronise both asynchronous inputs; the button idles high so its chain resets to ones.
  always_ff @(posedge CLK_100MHZ or negedge RESET) begin
    if (!RESET) begin
      lock_sync <= '0;
      btn_sync  <= '1;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_n};
    end
  end

  // Accept a new button level only after DEBOUNCE_CYCLES consecutive differing samples.
  // The counter clears on acceptance, so it stops at DB_LAST and can never wrap.
  always_ff @(posedge CLK_100MHZ or negedge RESET) begin
    if (!RESET) begin
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // Release sequencer: hold, then release channels in ascending order; ok==0 overrides everything.
  always_ff @(posedge CLK_100MHZ or negedge RESET) begin
    if (!RESET) begin
      state     <= S_WAIT_LOCK;
      rst_n_out <= '0;
      ready     <= 1'b0;
      cnt       <= '0;
      ch        <= '0;
    end else if (!ok) begin
      state     <= S_WAIT_LOCK;
      rst_n_out <= '0;
      ready     <= 1'b0;
      cnt       <= '0;
      ch        <= '0;
    end else begin
      case (state)
        S_WAIT_LOCK: begin
          state <= S_HOLD;
          cnt   <= '0;
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            rst_n_out[0] <= 1'b1;
            cnt          <= '0;
            if (N_CH == 1) begin
              state <= S_RUN;
              ready <= 1'b1;
            end else begin
              state <= S_STAGGER;
              ch    <= CH_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_STAGGER: begin
          if (cnt == STAGGER_LAST) begin
            for (int i = 0; i < N_CH; i++) begin
              if (CH_W'(i) == ch) rst_n_out[i] <= 1'b1;
            end
            ch  <= ch + CH_W'(1);
            cnt <= '0;
            if (ch == LAST_CH) begin
              state <= S_RUN;
              ready <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          // RUN: outputs hold, nothing counts.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: main instance (3 channels) and a minimal sweep instance.
// Edge numbering: inputs change #1 after "edge 0"; edge n is the n-th following rising edge.
// Outputs are sampled #1 after each rising edge.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll;
  logic       btn;
  logic       lock2;
  logic [2:0] rst3;
  logic       rdy;
  logic [1:0] st;
  logic [0:0] rst1;
  logic       rdy2;
  logic [1:0] st2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .N_CH(3), .SYNC_STAGES(2), .HOLD_CYCLES(16), .STAGGER_CYCLES(4), .DEBOUNCE_CYCLES(8)
  ) dut (
    .CLK_100MHZ(clk), .RESET(rst_n), .pll_locked(pll), .btn_n(btn),
    .rst_n_out(rst3), .ready(rdy), .state(st)
  );

  reset_sequencer #(
    .N_CH(1), .SYNC_STAGES(2), .HOLD_CYCLES(1), .STAGGER_CYCLES(1), .DEBOUNCE_CYCLES(8)
  ) dut_min (
    .CLK_100MHZ(clk), .RESET(rst_n), .pll_locked(lock2), .btn_n(btn),
    .rst_n_out(rst1), .ready(rdy2), .state(st2)
  );

  // Expected {rst_n_out, ready, state} e edges after ok's source input rose at edge 0.
  // Hold entry at 3, channel 0 at 19, channel 1 at 23, channel 2 + ready at 27.
  function automatic logic [5:0] prof(int e);
    if (e >= 27)      prof = {3'b111, 1'b1, 2'd3};
    else if (e >= 23) prof = {3'b011, 1'b0, 2'd2};
    else if (e >= 19) prof = {3'b001, 1'b0, 2'd2};
    else if (e >= 3)  prof = {3'b000, 1'b0, 2'd1};
    else              prof = {3'b000, 1'b0, 2'd0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [5:0] exp;
    rst_n = 1'b0; pll = 1'b1; btn = 1'b1; lock2 = 1'b1;
    repeat (4) begin
      tick;
      tests++;
      if ({rst3, rdy, st} !== 6'b0) begin
        fails++;
        $display("FAIL reset_hold got=%h want=00", {rst3, rdy, st});
      end
      tests++;
      if ({rst1, rdy2, st2} !== 4'b0) begin
        fails++;
        $display("FAIL reset_hold_min got=%h want=0", {rst1, rdy2, st2});
      end
    end
    // Releasing RESET with lock already high acts as edge 0.
    rst_n = 1'b1;
    repeat (21) tick;
    exp = prof(21);
    tests++;
    if ({rst3, rdy, st} !== exp) begin
      fails++;
      $display("FAIL reset_midseq_pre got=%h want=%h", {rst3, rdy, st}, exp);
    end
    // Assert RESET mid-cycle: clear must be asynchronous.
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({rst3, rdy, st} !== 6'b0) begin
      fails++;
      $display("FAIL reset_async got=%h want=00", {rst3, rdy, st});
    end
    repeat (5) begin
      tick;
      tests++;
      if ({rst3, rdy, st} !== 6'b0) begin
        fails++;
        $display("FAIL reset_midseq_hold got=%h want=00", {rst3, rdy, st});
      end
    end
  endtask

  task automatic test_sequence;
    logic [5:0] exp;
    pll = 1'b0;
    rst_n = 1'b1;
    repeat (4) tick;
    tests++;
    if ({rst3, rdy, st} !== 6'b0) begin
      fails++;
      $display("FAIL seq_wait_lock got=%h want=00", {rst3, rdy, st});
    end
    pll = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick;
      exp = prof(e);
      tests++;
      if ({rst3, rdy, st} !== exp) begin
        fails++;
        $display("FAIL seq edge=%0d got=%h want=%h", e, {rst3, rdy, st}, exp);
      end
    end
  endtask

  task automatic test_lock_glitch;
    logic [5:0] exp;
    pll = 1'b0;
    for (int e = 1; e <= 33; e++) begin
      tick;
      if (e == 1) pll = 1'b1;
      exp = (e <= 2) ? {3'b111, 1'b1, 2'd3} : prof(e - 1);
      tests++;
      if ({rst3, rdy, st} !== exp) begin
        fails++;
        $display("FAIL lock_glitch edge=%0d got=%h want=%h", e, {rst3, rdy, st}, exp);
      end
    end
  endtask

  task automatic test_button;
    logic [5:0] exp;
    for (int r = 0; r < 3; r++) begin
      btn = 1'b0;
      for (int c = 0; c < 9; c++) begin
        tick;
        if (c == 4) btn = 1'b1;
        tests++;
        if ({rst3, rdy, st} !== {3'b111, 1'b1, 2'd3}) begin
          fails++;
          $display("FAIL btn_bounce rep=%0d cyc=%0d got=%h want=3b", r, c, {rst3, rdy, st});
        end
      end
    end
    // Long press: btn_db falls at edge 10, channels assert at 11; release accepted at 22.
    btn = 1'b0;
    for (int e = 1; e <= 50; e++) begin
      tick;
      if (e == 12) btn = 1'b1;
      exp = (e <= 10) ? {3'b111, 1'b1, 2'd3} : prof(e - 20);
      tests++;
      if ({rst3, rdy, st} !== exp) begin
        fails++;
        $display("FAIL btn_press edge=%0d got=%h want=%h", e, {rst3, rdy, st}, exp);
      end
    end
  endtask

  task automatic test_drop_in_stagger;
    logic [5:0] exp;
    pll = 1'b0;
    repeat (6) tick;
    pll = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick;
      if (e == 24) pll = 1'b0;
      // Edge 27 would release channel 2, but the lock loss wins.
      if (e <= 24)      exp = prof(e);
      else if (e <= 26) exp = {3'b011, 1'b0, 2'd2};
      else              exp = 6'b0;
      tests++;
      if ({rst3, rdy, st} !== exp) begin
        fails++;
        $display("FAIL stagger_drop edge=%0d got=%h want=%h", e, {rst3, rdy, st}, exp);
      end
      tests++;
      if (!(rst3 inside {3'b000, 3'b001, 3'b011, 3'b111}) || (rdy !== (rst3 == 3'b111))) begin
        fails++;
        $display("FAIL prefix_invariant edge=%0d rst=%b ready=%b", e, rst3, rdy);
      end
    end
    pll = 1'b1;
  endtask

  task automatic test_min_params;
    logic [3:0] exp;
    lock2 = 1'b0;
    repeat (4) tick;
    tests++;
    if ({rst1, rdy2, st2} !== 4'b0) begin
      fails++;
      $display("FAIL min_idle got=%h want=0", {rst1, rdy2, st2});
    end
    lock2 = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick;
      if (e >= 4)      exp = {1'b1, 1'b1, 2'd3};
      else if (e == 3) exp = {1'b0, 1'b0, 2'd1};
      else             exp = 4'b0;
      tests++;
      if ({rst1, rdy2, st2} !== exp) begin
        fails++;
        $display("FAIL min_release edge=%0d got=%h want=%h", e, {rst1, rdy2, st2}, exp);
      end
    end
    lock2 = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick;
      exp = (e <= 2) ? {1'b1, 1'b1, 2'd3} : 4'b0;
      tests++;
      if ({rst1, rdy2, st2} !== exp) begin
        fails++;
        $display("FAIL min_drop edge=%0d got=%h want=%h", e, {rst1, rdy2, st2}, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_sequence;
    test_lock_glitch;
    test_button;
    test_drop_in_stagger;
    test_min_params;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
